tick_monitor: RTL
=================

// Module: tick_monitor
// PURPOSE
//  Receive-side companion to the slow-clock generator. Takes a slow square wave
//  (e.g. clk_1Hz / clk_2Hz) and brings it into the fast clk domain. Emits
//  single-cycle rise/fall tick enables, measures every half-period in clk
//  cycles, and reports lock/fault status to the parking controller.
// PARAMETERS
//  NOMINAL_HALF  20_000_000  expected half-period in clk cycles
//  TOL           1_000       allowed +/- deviation from NOMINAL_HALF, in cycles
//  LOCK_COUNT    4           consecutive good half-periods required for lock
//  CNT_W         26          counter/measurement width; must hold 2*(NOMINAL_HALF+TOL)
//  SYNC_STAGES   2           synchroniser depth, minimum 2
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-low reset
//  slow_in      in   1      asynchronous slow square wave
//  clear_err    in   1      clears sticky too_fast/too_slow
//  tick_rise    out  1      1-cycle pulse per rising edge of slow_in
//  tick_fall    out  1      1-cycle pulse per falling edge of slow_in
//  half_period  out  CNT_W  last measured half-period, in cycles
//  period_valid out  1      1-cycle pulse when half_period updates
//  locked       out  1      high in LOCKED state
//  lost         out  1      high in LOST state
//  too_fast     out  1      sticky: half-period < NOMINAL_HALF-TOL was seen
//  too_slow     out  1      sticky: half-period > NOMINAL_HALF+TOL was seen
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk): sync chain, all outputs, cnt and good_cnt
//    go to 0; state=ACQUIRE. Reset mid-measurement discards everything.
//  - slow_in passes through SYNC_STAGES flops, then an edge-detect register.
//    tick_* asserts SYNC_STAGES+1 cycles after the first posedge that samples
//    the new level. Ticks are registered and never both high in one cycle.
//  - cnt clears to 0 on an edge cycle, otherwise increments, saturating at
//    2^CNT_W-1. On an edge: half_period <= cnt+1, i.e. the cycle distance
//    between consecutive synchronised edges.
//  - good = |half_period - NOMINAL_HALF| <= TOL. Compare in CNT_W+1 bits, no wrap.
//  - FSM:
//    ACQUIRE: first edge -> MEASURE. No measurement taken, period_valid stays 0.
//    MEASURE: each edge measures and pulses period_valid. good -> good_cnt++,
//             else good_cnt=0. When good_cnt reaches LOCK_COUNT -> LOCKED.
//    LOCKED:  good edge -> stay. Bad edge -> MEASURE with good_cnt=0.
//    LOST:    next edge -> MEASURE. No measurement on that edge.
//    Any state: cnt reaches 2*(NOMINAL_HALF+TOL) with no edge -> LOST.
//    The timeout fires once; cnt keeps saturating afterwards.
//  - Bad measurement sets too_fast or too_slow (and outputs updated same cycle
//    as period_valid). Sticky until clear_err. If clear_err coincides with a new
//    error, the new error wins (flag stays 1).
//  - Timeout coinciding with an edge: the edge wins and no LOST entry occurs.
// CONFIGURATION
//  TICK_MON_HIST_EN defined: adds outputs min_half, max_half [CNT_W-1:0].
//    They track the min/max of half_period over all period_valid pulses.
//    Reset values: min_half=all-ones, max_half=0. clear_err re-initialises
//    both to those values.
//  Undefined: these ports and their registers do not exist. All other
//    behaviour is identical.
// TESTING  (bench params: NOMINAL_HALF=20, TOL=2, LOCK_COUNT=3, CNT_W=8)
//  1. reset=0 for 3 cycles, slow_in toggling -> all outputs 0, no ticks.
//  2. slow_in toggles every 20 cycles -> first edge gives no period_valid.
//     Next edges give half_period=20. locked=1 on the cycle of the 4th edge.
//  3. Locked, one half-period of 17 -> too_fast=1, locked=0.
//     3 more x20 -> relocked. clear_err -> too_fast=0.
//  4. Locked, slow_in held for 44 cycles -> lost=1 at cnt=44.
//     Next edge -> MEASURE, then relock after 3 good x20.
//  5. Half-periods 22 then 23 -> 22 counts as good, 23 sets too_slow.
//     clear_err pulsed on the cycle of the 23 measurement -> too_slow stays 1.
//  6. Assert reset mid-LOCKED -> next cycle all outputs 0, state ACQUIRE.
//     With TICK_MON_HIST_EN: min/max over 18,20,22 -> min_half=18, max_half=22.

Source files
------------

// File: rtl/tick_monitor.sv
// Synchronises a slow square wave into clk, emits rise/fall ticks, measures half-periods
// and tracks lock/lost/error status. Define TICK_MON_HIST_EN to add min_half/max_half tracking.
module tick_monitor #(
    parameter int unsigned NOMINAL_HALF = 20_000_000,
    parameter int unsigned TOL          = 1_000,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_in,
    input  logic             clear_err,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic             too_fast,
`ifdef TICK_MON_HIST_EN
    output logic             too_slow,
    output logic [CNT_W-1:0] min_half,
    output logic [CNT_W-1:0] max_half
`else
    output logic             too_slow
`endif
);

    localparam int unsigned W1   = CNT_W + 1;
    localparam int unsigned GC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * (NOMINAL_HALF + TOL));
    localparam logic [W1-1:0]    LO_LIM  = W1'((NOMINAL_HALF > TOL) ? (NOMINAL_HALF - TOL) : 0);
    localparam logic [W1-1:0]    HI_LIM  = W1'(NOMINAL_HALF + TOL);
    localparam logic [GC_W-1:0]  GC_LOCK = GC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_ACQUIRE,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   det_q, det_d;
    logic                   det_prev_q, det_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GC_W-1:0]        good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]       half_period_q, half_period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   tick_rise_q, tick_rise_d;
    logic                   tick_fall_q, tick_fall_d;
    logic                   locked_q, locked_d;
    logic                   lost_q, lost_d;
    logic                   too_fast_q, too_fast_d;
    logic                   too_slow_q, too_slow_d;
`ifdef TICK_MON_HIST_EN
    logic [CNT_W-1:0]       min_half_q, min_half_d;
    logic [CNT_W-1:0]       max_half_q, max_half_d;
`endif

    logic             edge_c;
    logic [W1-1:0]    meas_c;
    logic [CNT_W-1:0] meas_sat_c;
    logic             fast_c;
    logic             slow_c;
    logic             good_c;
    logic [GC_W-1:0]  gc_inc_c;

    // Edge is seen between the edge-detect register and its delayed copy.
    assign edge_c     = det_q ^ det_prev_q;
    assign meas_c     = {1'b0, cnt_q} + W1'(1);
    assign meas_sat_c = meas_c[CNT_W] ? CNT_MAX : meas_c[CNT_W-1:0];
    assign fast_c     = (meas_c < LO_LIM);
    assign slow_c     = (meas_c > HI_LIM);
    assign good_c     = !fast_c && !slow_c;
    assign gc_inc_c   = good_cnt_q + GC_W'(1);

    always_comb begin
        state_d        = state_q;
        sync_d         = {sync_q[SYNC_STAGES-2:0], slow_in};
        det_d          = sync_q[SYNC_STAGES-1];
        det_prev_d     = det_q;
        cnt_d          = cnt_q;
        good_cnt_d     = good_cnt_q;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        tick_rise_d    = 1'b0;
        tick_fall_d    = 1'b0;
        too_fast_d     = too_fast_q;
        too_slow_d     = too_slow_q;
`ifdef TICK_MON_HIST_EN
        min_half_d     = min_half_q;
        max_half_d     = max_half_q;
`endif

        if (clear_err) begin
            too_fast_d = 1'b0;
            too_slow_d = 1'b0;
`ifdef TICK_MON_HIST_EN
            min_half_d = CNT_MAX;
            max_half_d = '0;
`endif
        end

        if (edge_c) begin
            tick_rise_d = det_q;
            tick_fall_d = !det_q;
            cnt_d       = '0;
            if (state_q == ST_ACQUIRE || state_q == ST_LOST) begin
                state_d    = ST_MEASURE;
                good_cnt_d = '0;
            end else begin
                // New errors are applied after the clear so they win.
                period_valid_d = 1'b1;
                half_period_d  = meas_sat_c;
                if (fast_c) too_fast_d = 1'b1;
                if (slow_c) too_slow_d = 1'b1;
`ifdef TICK_MON_HIST_EN
                if (meas_sat_c < min_half_d) min_half_d = meas_sat_c;
                if (meas_sat_c > max_half_d) max_half_d = meas_sat_c;
`endif
                if (good_c) begin
                    if (state_q == ST_MEASURE) begin
                        good_cnt_d = gc_inc_c;
                        if (gc_inc_c >= GC_LOCK) state_d = ST_LOCKED;
                    end
                end else begin
                    good_cnt_d = '0;
                    state_d    = ST_MEASURE;
                end
            end
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_d == TIMEOUT && cnt_q != TIMEOUT && state_q != ST_LOST) begin
                state_d    = ST_LOST;
                good_cnt_d = '0;
            end
        end

        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_ACQUIRE;
            sync_q         <= '0;
            det_q          <= 1'b0;
            det_prev_q     <= 1'b0;
            cnt_q          <= '0;
            good_cnt_q     <= '0;
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
            tick_rise_q    <= 1'b0;
            tick_fall_q    <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
            too_fast_q     <= 1'b0;
            too_slow_q     <= 1'b0;
`ifdef TICK_MON_HIST_EN
            min_half_q     <= CNT_MAX;
            max_half_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            det_q          <= det_d;
            det_prev_q     <= det_prev_d;
            cnt_q          <= cnt_d;
            good_cnt_q     <= good_cnt_d;
            half_period_q  <= half_period_d;
            period_valid_q <= period_valid_d;
            tick_rise_q    <= tick_rise_d;
            tick_fall_q    <= tick_fall_d;
            locked_q       <= locked_d;
            lost_q         <= lost_d;
            too_fast_q     <= too_fast_d;
            too_slow_q     <= too_slow_d;
`ifdef TICK_MON_HIST_EN
            min_half_q     <= min_half_d;
            max_half_q     <= max_half_d;
`endif
        end
    end

    assign tick_rise    = tick_rise_q;
    assign tick_fall    = tick_fall_q;
    assign half_period  = half_period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign too_fast     = too_fast_q;
    assign too_slow     = too_slow_q;
`ifdef TICK_MON_HIST_EN
    assign min_half     = min_half_q;
    assign max_half     = max_half_q;
`endif

endmodule
